// File: rtl/mau_pkg.sv
// Shared types and helpers for the MEM-stage access sequencer.
package mau_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LD_HI  = 2'd1,
        ST_SEQ = 2'd2
    } mau_state_e;

    // Access size in bytes; unused encodings behave as a word.
    function automatic logic [2:0] dm_size(input logic [2:0] t);
        logic [2:0] s;
        case (t)
            DM_HALF, DM_HALF_U: s = 3'd2;
            DM_BYTE, DM_BYTE_U: s = 3'd1;
            default:            s = 3'd4;
        endcase
        return s;
    endfunction

    // DMType presented to memory: stores drop signedness, unused codes become word.
    function automatic logic [2:0] dm_map(input logic [2:0] t, input logic we);
        logic [2:0] m;
        case (t)
            DM_HALF, DM_BYTE:   m = t;
            DM_HALF_U:          m = we ? DM_HALF : DM_HALF_U;
            DM_BYTE_U:          m = we ? DM_BYTE : DM_BYTE_U;
            default:            m = DM_WORD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of the access sequencer.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic              done;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] dm_addr;
    logic              dm_wr;
    logic [2:0]        dm_type;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;

    // Pipeline plus data memory side.
    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata, dm_dout,
        input  stall, done, rdata, dm_addr, dm_wr, dm_type, dm_din
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata, dm_dout,
        output stall, done, rdata, dm_addr, dm_wr, dm_type, dm_din
    );
endinterface

// File: rtl/mau_load_align.sv
// Extracts a load value from a byte window at a byte offset and extends it.
module mau_load_align
    import mau_pkg::*;
(
    input  logic [63:0] window_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  type_i,
    output logic [31:0] data_o
);

    logic [31:0] sel;

    assign sel = 32'(window_i >> {off_i, 3'b000});

    always_comb begin
        data_o = sel;
        case (type_i)
            DM_HALF:   data_o = {{16{sel[15]}}, sel[15:0]};
            DM_HALF_U: data_o = {16'h0000, sel[15:0]};
            DM_BYTE:   data_o = {{24{sel[7]}}, sel[7:0]};
            DM_BYTE_U: data_o = {24'h000000, sel[7:0]};
            default:   data_o = sel;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: passes aligned accesses through, splits misaligned
// loads into two word reads and misaligned stores into byte writes.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
)(
    input  logic             clk,
    input  logic             rstn,
    mem_access_unit_if.slave bus
);

    mau_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] lo_buf_q, lo_buf_d;

    logic [1:0]        off;
    logic [2:0]        size;
    logic              misaligned;
    logic [ADDR_W-1:0] aligned_addr;
    logic [7:0]        st_byte;
    logic [63:0]       win;
    logic [1:0]        win_off;
    logic [31:0]       ld_res;

    logic              stall;
    logic              done;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] dm_addr;
    logic              dm_wr;
    logic [2:0]        dm_type;
    logic [31:0]       dm_din;

    assign off          = bus.req_addr[1:0];
    assign size         = dm_size(bus.req_type);
    assign misaligned   = ((size == 3'd4) && (off != 2'd0)) || ((size == 3'd2) && off[0]);
    assign aligned_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
    assign st_byte      = bus.req_wdata[{cnt_q, 3'b000} +: 8];

    // Second half of a split load joins the buffered low word; otherwise the memory word as-is.
    assign win     = (state_q == LD_HI) ? {bus.dm_dout, lo_buf_q} : {32'h0000_0000, bus.dm_dout};
    assign win_off = (state_q == LD_HI) ? off : 2'd0;

    mau_load_align u_align (
        .window_i (win),
        .off_i    (win_off),
        .type_i   (bus.req_type),
        .data_o   (ld_res)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            lo_buf_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lo_buf_q <= lo_buf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lo_buf_d = lo_buf_q;
        dm_addr  = bus.req_addr;
        dm_type  = dm_map(bus.req_type, bus.req_we);
        dm_din   = bus.req_wdata;
        dm_wr    = 1'b0;
        stall    = 1'b0;
        done     = 1'b0;
        rdata    = 32'h0000_0000;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && misaligned && !bus.req_we) begin
                    dm_addr  = aligned_addr;
                    dm_type  = DM_WORD;
                    stall    = 1'b1;
                    lo_buf_d = bus.dm_dout;
                    state_d  = LD_HI;
                end else if (bus.req_valid && misaligned) begin
                    dm_type = DM_BYTE;
                    dm_din  = {24'h000000, bus.req_wdata[7:0]};
                    dm_wr   = 1'b1;
                    stall   = 1'b1;
                    cnt_d   = 2'd1;
                    state_d = ST_SEQ;
                end else begin
                    dm_wr = bus.req_valid & bus.req_we;
                    done  = bus.req_valid;
                    if (bus.req_valid && !bus.req_we) begin
                        rdata = ld_res;
                    end
                end
            end

            LD_HI: begin
                dm_addr = aligned_addr + ADDR_W'(4);
                dm_type = DM_WORD;
                state_d = IDLE;
                if (bus.req_valid) begin
                    done = 1'b1;
                    if (!bus.req_we) begin
                        rdata = ld_res;
                    end
                end
            end

            ST_SEQ: begin
                dm_type = DM_BYTE;
                dm_addr = bus.req_addr + ADDR_W'(cnt_q);
                dm_din  = {24'h000000, st_byte};
                if (!bus.req_valid) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    dm_wr = 1'b1;
                    if (cnt_q == 2'(size - 3'd1)) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase

        // Held reset silences every control output.
        if (!rstn) begin
            dm_wr = 1'b0;
            stall = 1'b0;
            done  = 1'b0;
            rdata = 32'h0000_0000;
        end
    end

    assign bus.stall   = stall;
    assign bus.done    = done;
    assign bus.rdata   = rdata;
    assign bus.dm_addr = dm_addr;
    assign bus.dm_wr   = dm_wr;
    assign bus.dm_type = dm_type;
    assign bus.dm_din  = dm_din;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized back-to-back
// requests checked against a byte-level reference memory.
module tb_mem_access_unit;

    localparam int unsigned ADDR_W = 32;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    int checks = 0;
    int errors = 0;

    // Data memory: word-aligned read shifted to the byte address, extended per DMType.
    always_comb begin
        logic [31:0] w;
        logic [7:0]  a;
        a = {bus.dm_addr[7:2], 2'b00};
        w = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
        w = w >> {bus.dm_addr[1:0], 3'b000};
        case (bus.dm_type)
            3'b001:  bus.dm_dout = {{16{w[15]}}, w[15:0]};
            3'b010:  bus.dm_dout = {16'h0, w[15:0]};
            3'b011:  bus.dm_dout = {{24{w[7]}}, w[7:0]};
            3'b100:  bus.dm_dout = {24'h0, w[7:0]};
            default: bus.dm_dout = w;
        endcase
    end

    function automatic int tsize(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 2;
        if (t == 3'd3 || t == 3'd4) return 1;
        return 4;
    endfunction

    function automatic bit is_mis(input logic [2:0] t, input logic [31:0] a);
        return (tsize(t) == 4 && a[1:0] != 2'd0) || (tsize(t) == 2 && a[0]);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] t);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < tsize(t); i++) v[8*i +: 8] = ref_mem[8'(a + 32'(i))];
        if (t == 3'd1) v = {{16{v[15]}}, v[15:0]};
        if (t == 3'd3) v = {{24{v[7]}}, v[7:0]};
        return v;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem[8'(a + 32'(i))]     = w[8*i +: 8];
            ref_mem[8'(a + 32'(i))] = w[8*i +: 8];
        end
    endtask

    // Called at the negedge: let the clock edge happen, then commit any memory write.
    task automatic advance();
        logic w;
        logic [31:0] a, d;
        logic [2:0] t;
        w = bus.dm_wr; a = bus.dm_addr; d = bus.dm_din; t = bus.dm_type;
        @(posedge clk);
        #1;
        if (w === 1'b1) for (int i = 0; i < tsize(t); i++) mem[8'(a + 32'(i))] = d[8*i +: 8];
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid = v; bus.req_we = we; bus.req_type = t;
        bus.req_addr = a; bus.req_wdata = wd;
    endtask

    // Full request against the reference model; stays valid until done.
    task automatic run_req(input string nm, input logic we, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] wd);
        int sz, ncyc;
        bit mis, last;
        logic [31:0] exp_rd, exp_a;
        sz = tsize(t);
        mis = is_mis(t, a);
        ncyc = !mis ? 1 : (we ? sz : 2);
        exp_rd = we ? 32'h0 : ref_load(a, t);
        drive(1'b1, we, t, a, wd);
        for (int c = 0; c < ncyc; c++) begin
            last = (c == ncyc - 1);
            @(negedge clk);
            checks++;
            if (bus.stall !== !last || bus.done !== last) begin
                errors++;
                $display("FAIL %s cyc%0d stall/done got %b/%b want %b/%b", nm, c, bus.stall, bus.done, !last, last);
            end
            if (we) begin
                exp_a = mis ? a + 32'(c) : a;
                checks++;
                if (bus.dm_wr !== 1'b1 || bus.dm_addr !== exp_a) begin
                    errors++;
                    $display("FAIL %s cyc%0d wr/addr got %b/%h want 1/%h", nm, c, bus.dm_wr, bus.dm_addr, exp_a);
                end
                if (mis) begin
                    checks++;
                    if (bus.dm_din[7:0] !== wd[8*c +: 8]) begin
                        errors++;
                        $display("FAIL %s cyc%0d din got %h want %h", nm, c, bus.dm_din[7:0], wd[8*c +: 8]);
                    end
                end
            end else begin
                checks++;
                if (bus.dm_wr !== 1'b0 || bus.rdata !== (last ? exp_rd : 32'h0)) begin
                    errors++;
                    $display("FAIL %s cyc%0d wr/rdata got %b/%h want 0/%h", nm, c, bus.dm_wr, bus.rdata, last ? exp_rd : 32'h0);
                end
            end
            advance();
        end
        if (we) for (int i = 0; i < sz; i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(1'b1, 1'b1, 3'd0, 32'h31, 32'h1234_5678);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.dm_wr !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset stall/done/wr/rdata got %b/%b/%b/%h want 0/0/0/0", bus.stall, bus.done, bus.dm_wr, bus.rdata);
        end
        advance();
        advance();
        rstn = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.dm_wr !== 1'b0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle done/wr/stall got %b/%b/%b want 0/0/0", bus.done, bus.dm_wr, bus.stall);
        end
        advance();
    endtask

    task automatic test_aligned_load();
        preload(32'h10, 32'hDEAD_BEEF);
        run_req("lw_aligned", 1'b0, 3'd0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 3'd0, 32'h10, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.rdata !== 32'hDEAD_BEEF || bus.done !== 1'b1 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL lw_const rdata/done/stall got %h/%b/%b want deadbeef/1/0", bus.rdata, bus.done, bus.stall);
        end
        advance();
        bus.req_valid = 1'b0;
    endtask

    task automatic mis_load(input string nm, input logic [2:0] t, input logic [31:0] a,
                            input logic [31:0] lo_a, input logic [31:0] hi_a, input logic [31:0] exp);
        drive(1'b1, 1'b0, t, a, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || bus.done !== 1'b0 || bus.dm_addr !== lo_a || bus.dm_wr !== 1'b0) begin
            errors++;
            $display("FAIL %s c0 stall/done/addr got %b/%b/%h want 1/0/%h", nm, bus.stall, bus.done, bus.dm_addr, lo_a);
        end
        advance();
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b1 || bus.dm_addr !== hi_a || bus.rdata !== exp) begin
            errors++;
            $display("FAIL %s c1 stall/done/addr/rdata got %b/%b/%h/%h want 0/1/%h/%h", nm, bus.stall, bus.done, bus.dm_addr, bus.rdata, hi_a, exp);
        end
        advance();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_misaligned_load();
        preload(32'h20, 32'h8877_6655);
        preload(32'h24, 32'h0000_00F1);
        mis_load("lh_23", 3'd1, 32'h23, 32'h20, 32'h24, 32'hFFFF_F188);
        mis_load("lhu_23", 3'd2, 32'h23, 32'h20, 32'h24, 32'h0000_F188);
    endtask

    task automatic test_misaligned_store();
        run_req("sw_31", 1'b1, 3'd0, 32'h31, 32'h1234_5678);
        drive(1'b1, 1'b0, 3'd0, 32'h30, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.rdata[31:8] !== 24'h345678 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL lw_30 rdata/done got %h/%b want 345678xx/1", bus.rdata, bus.done);
        end
        advance();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_wrap();
        preload(32'hFFFF_FFFC, 32'hA1B2_C3D4);
        preload(32'h0000_0000, 32'h5566_7788);
        mis_load("lw_wrap", 3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 32'h7788_A1B2);
    endtask

    task automatic test_flush();
        preload(32'h40, 32'h1122_3344);
        drive(1'b1, 1'b1, 3'd0, 32'h41, 32'hAABB_CCDD);
        @(negedge clk);
        checks++;
        if (bus.dm_wr !== 1'b1 || bus.stall !== 1'b1 || bus.dm_addr !== 32'h41) begin
            errors++;
            $display("FAIL flush_c0 wr/stall/addr got %b/%b/%h want 1/1/41", bus.dm_wr, bus.stall, bus.dm_addr);
        end
        advance();
        bus.req_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.dm_wr !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
                errors++;
                $display("FAIL flush_c%0d wr/done/stall got %b/%b/%b want 0/0/0", c, bus.dm_wr, bus.done, bus.stall);
            end
            advance();
        end
        ref_mem[8'h41] = 8'hDD;
        run_req("lw_40_after_flush", 1'b0, 3'd0, 32'h40, 32'h0);
        drive(1'b1, 1'b0, 3'd0, 32'h40, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.rdata !== 32'h1122_DD44) begin
            errors++;
            $display("FAIL flush_mem got %h want 1122dd44", bus.rdata);
        end
        advance();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        preload(32'h50, 32'h0000_0000);
        drive(1'b1, 1'b1, 3'd0, 32'h51, 32'hCAFE_BABE);
        @(negedge clk); advance();
        @(negedge clk); advance();
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.dm_wr !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid stall/done/wr got %b/%b/%b want 0/0/0", bus.stall, bus.done, bus.dm_wr);
        end
        advance();
        rstn = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.dm_wr !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle stall/done/wr got %b/%b/%b want 0/0/0", bus.stall, bus.done, bus.dm_wr);
        end
        advance();
        ref_mem[8'h51] = 8'hBE;
        ref_mem[8'h52] = 8'hBA;
        run_req("lw_50_after_rst", 1'b0, 3'd0, 32'h50, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [2:0] t;
        logic we;
        logic [31:0] a, wd;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            t  = 3'($urandom_range(0, 7));
            a  = $urandom;
            wd = $urandom;
            run_req("rand", we, t, a, wd);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                advance();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        test_reset();
        test_aligned_load();
        test_misaligned_load();
        test_misaligned_store();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access sequencer in the MEM stage, directly upstream of the data memory. It accepts one load/store request per instruction from the EX/MEM register and passes aligned accesses through in the same cycle. It splits misaligned accesses into a sequence of aligned data-memory operations. While a sequence is in progress it stalls the pipeline, and it returns the assembled, sign- or zero-extended load result.

## Interface
- ADDR_W, 32, address width of request and memory port
- clk  in  1  pipeline clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  MEM-stage instruction is a load/store; held stable while stall=1
- req_we  in  1  1 = store, 0 = load
- req_type  in  3  DMType: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- stall  out  1  freeze PC/IF/ID/EX/MEM registers
- done  out  1  request completes this cycle
- rdata  out  32  load result, valid when done=1 and req_we=0, else 0
- dm_addr  out  ADDR_W  to data memory addr
- dm_wr  out  1  to data memory DMWr
- dm_type  out  3  to data memory DMType
- dm_din  out  32  to data memory din
- dm_dout  in  32  combinational read data from data memory

## Operation
- Size: word = 4, half = 2, byte = 1. Types 101–111 are treated as word.
- Store type mapping: 010 → 001, 100 → 011.
- off = req_addr[1:0]. A request is misaligned when it is a word with off≠0, or a half with off∈{1,3}. Bytes are never misaligned.
- The FSM has three states: IDLE, LD_HI and ST_SEQ. It uses a 2-bit byte counter cnt and a 32-bit lo_buf.
- IDLE, aligned or req_valid=0:
  - Pass-through: dm_addr=req_addr, dm_type=mapped type, dm_din=req_wdata, dm_wr=req_valid&req_we.
  - rdata=dm_dout, done=req_valid, stall=0.
- IDLE, misaligned load:
  - dm_addr={req_addr[ADDR_W-1:2],2'b00}, dm_type=word, dm_wr=0.
  - stall=1, done=0.
  - lo_buf<=dm_dout, then go to LD_HI.
- LD_HI:
  - dm_addr = aligned address + 4, modulo 2^ADDR_W (wrap permitted), dm_type=word.
  - Window = {dm_dout, lo_buf} >> (8·off); the low size bytes are extracted and extended per req_type. This is rdata.
  - done=1, stall=0, then go to IDLE.
- IDLE, misaligned store:
  - Issue byte 0: dm_type=byte, dm_addr=req_addr, dm_din={24'b0, req_wdata[7:0]}, dm_wr=1.
  - stall=1, cnt<=1, then go to ST_SEQ.
- ST_SEQ:
  - dm_type=byte, dm_addr=req_addr+cnt (wraps), dm_din low byte=req_wdata[8·cnt+:8], dm_wr=1.
  - If cnt = size−1: done=1, stall=0, go to IDLE, cnt<=0.
  - Otherwise: stall=1, cnt<=cnt+1.
- Flush: req_valid=0 in LD_HI or ST_SEQ aborts the sequence.
  - dm_wr=0 and done=0 that cycle, then return to IDLE.
  - Bytes already written remain in memory.
- Reset (rstn=0 at a clock edge):
  - Next state is IDLE; cnt=0 and lo_buf=0.
  - While rstn=0, dm_wr=0, stall=0, done=0 and rdata=0. dm_addr, dm_type and dm_din are don't-care.
  - Reset mid-sequence leaves a partial store partially written.

## Timing
- Aligned access: 0 extra cycles; done is combinational from the request in the same cycle.
- Misaligned load: 2 cycles. stall=1 in cycle 0; done and rdata in cycle 1.
- Misaligned half store: 2 cycles. Misaligned word store: 4 cycles. stall=1 in all but the last cycle.
- stall is combinational from the state and the current request. It must never be high in the cycle done=1.
- Back-to-back requests: a new request may be presented in the cycle after done. The FSM is in IDLE in that cycle.

## Structure
- Shared package `mau_pkg` holds:
  - DMType constants DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE and DM_BYTE_U.
  - The state enum IDLE / LD_HI / ST_SEQ.
  - A size-decode function.
- Sub-module `mau_load_align` is combinational. It takes the 64-bit window, off and type, and returns the extended 32-bit result. It is reused for the aligned path with window={32'b0, dm_dout}.
- Estimated size is about 150–250 lines of RTL.

## Test plan
- **Aligned word load:** mem[0x10]=0xDEADBEEF; request lw 0x10 → same cycle rdata=0xDEADBEEF, done=1, stall=0.
- **Misaligned signed half load:** mem[0x20]=0x8877_6655, mem[0x24]=0x0000_00F1; request lh 0x23 → cycle 0: stall=1, dm_addr=0x20; cycle 1: dm_addr=0x24, rdata=0xFFFF_F188. Repeat with lhu → 0x0000_F188.
- **Misaligned word store:** sw 0x12345678 to 0x31 → 4 cycles of byte writes at 0x31, 0x32, 0x33, 0x34 with data 78, 56, 34, 12. stall=1,1,1,0; done only in cycle 3. A follow-up lw 0x30 returns 0x345678xx.
- **Wrap:** misaligned lw at 0xFFFF_FFFE → the second access is at dm_addr=0x0000_0000.
- **Flush:** drop req_valid in the second cycle of a misaligned sw → only byte 0 is written; FSM is in IDLE and dm_wr=0 the next cycle.
- **Reset mid-op:** assert rstn=0 in ST_SEQ (cnt=2) → next cycle IDLE; stall=0, done=0, dm_wr=0. The next aligned request completes normally.
